// File: rtl/queue_drain_if.sv
// Handshake bundle for queue_drain: the Queue read side (request/response)
// and the downstream valid/ready message side.
interface queue_drain_if #(
  parameter int MSG_WIDTH = 8
);
  logic                 q_read_ack;
  logic                 q_read_en;
  logic [MSG_WIDTH-1:0] q_read;
  logic                 msg_valid;
  logic [MSG_WIDTH-1:0] msg_data;
  logic                 msg_ready;

  // The drain block: issues dequeue requests and presents messages.
  modport master (
    output q_read_ack,
    input  q_read_en,
    input  q_read,
    output msg_valid,
    output msg_data,
    input  msg_ready
  );

  // The environment: the Queue answering requests and the downstream consumer.
  modport slave (
    input  q_read_ack,
    output q_read_en,
    output q_read,
    input  msg_valid,
    input  msg_data,
    output msg_ready
  );
endinterface

// File: rtl/queue_drain.sv
// Consumer end of the Queue read interface. Pulses q_read_ack to dequeue one
// message, samples the Queue response after a settle window, and holds the
// message on a valid/ready handshake until downstream takes it. Empty
// responses back off for POLL_GAP cycles before polling again.
module queue_drain #(
  parameter int MSG_WIDTH = 8,
  parameter int SETTLE    = 2,   // 1..15
  parameter int POLL_GAP  = 4,   // 0..255
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  queue_drain_if.master        bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] msg_count,
  output logic [CNT_WIDTH-1:0] empty_polls
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_BACKOFF = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [7:0] GAP_LOAD    = 8'(POLL_GAP);

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [3:0]           settle_cnt;
  logic [7:0]           gap_cnt;
  logic                 ack_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [MSG_WIDTH-1:0] data_q;
  logic                 sample_now;

  // The settle window closes on the last SETTLE cycle; the Queue response is read then.
  assign sample_now = (state == S_SETTLE) && (settle_cnt == '0);

  // Next-state selection for the request / settle / hold / backoff cycle.
  always_comb begin
    // NOTE: next_state gets a default before the case so every path assigns it
    // and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:    if (enable) next_state = S_REQ;
      S_REQ:     next_state = S_SETTLE;
      S_SETTLE:  if (sample_now) next_state = bus.q_read_en ? S_HOLD : S_BACKOFF;
      S_HOLD:    if (bus.msg_ready) next_state = enable ? S_REQ : S_IDLE;
      S_BACKOFF: begin
        if (!enable)              next_state = S_IDLE;
        else if (gap_cnt == '0)   next_state = S_REQ;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  // State register plus registered ack/busy so the Queue sees a glitch-free request edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state  <= S_IDLE;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      ack_q  <= (next_state == S_REQ);
      busy_q <= (next_state != S_IDLE);
    end
  end

  // Settle and backoff timers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      gap_cnt    <= '0;
    end else begin
      if (state == S_REQ)
        settle_cnt <= SETTLE_LOAD;
      else if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;

      if (sample_now && !bus.q_read_en)
        gap_cnt <= GAP_LOAD;
      else if (state == S_BACKOFF && enable && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Message capture, downstream handshake and statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      msg_count   <= '0;
      empty_polls <= '0;
    end else begin
      if (sample_now) begin
        if (bus.q_read_en) begin
          data_q  <= bus.q_read;
          valid_q <= 1'b1;
        end else if (empty_polls != '1) begin
          empty_polls <= empty_polls + 1'b1;
        end
      end
      // msg_data is only rewritten on capture, so it stays put through HOLD.
      if (state == S_HOLD && bus.msg_ready) begin
        valid_q   <= 1'b0;
        msg_count <= msg_count + 1'b1;
      end
    end
  end

  assign bus.q_read_ack = ack_q;
  assign bus.msg_valid  = valid_q;
  assign bus.msg_data   = data_q;
  assign busy           = busy_q;

endmodule
